mux151_scan_ctrl: RTL and testbench

Scan controller for the IC74HC151 8-to-1 data selector. It drives the selector's enable and select lines, waits a fixed settling time on each channel, and samples the selected output `Y`. The eight samples are assembled into one parallel frame, which is handed to the consumer through a valid/ack handshake. The block supports single-shot and continuous scanning, and flags frames dropped because the consumer was slow.

---
 rtl/mux151_scan_ctrl.sv | 105 ++++++++++
 tb/tb_mux151_scan_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mux151_scan_ctrl.sv
// Scans a 74HC151 selector channel by channel and assembles the samples into a frame; DATA_IN*(SETTLE+1)+1 cycles from start to frame_valid.
// Frame handed off via valid/ack; a frame completing while the previous one is still unacknowledged is dropped and flagged in overrun.
module mux151_scan_ctrl #(
  parameter int DATA_IN = 8,
  parameter int SEL_W   = 3,
  parameter int SETTLE  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               cont,
  input  logic               ack,
  input  logic               mux_y,
  output logic               mux_e,
  output logic [SEL_W-1:0]   mux_sel,
  output logic [DATA_IN-1:0] frame,
  output logic               frame_valid,
  output logic               busy,
  output logic               overrun
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE - 1);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(DATA_IN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [SEL_W-1:0]   sel_nxt;
  logic [DATA_IN-1:0] scan_buf, buf_nxt;
  logic               done;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = mux_sel;
    buf_nxt   = scan_buf;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        sel_nxt = '0;
        if (start) state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt == LAST_CNT) begin
          cnt_nxt   = '0;
          state_nxt = ST_SAMPLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_SAMPLE: begin
        buf_nxt[mux_sel] = mux_y;
        if (mux_sel == LAST_SEL) begin
          done      = 1'b1;
          sel_nxt   = '0;
          state_nxt = cont ? ST_SETTLE : ST_IDLE;
        end else begin
          sel_nxt   = mux_sel + 1'b1;
          state_nxt = ST_SETTLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      mux_sel     <= '0;
      scan_buf    <= '0;
      frame       <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      mux_sel  <= sel_nxt;
      scan_buf <= buf_nxt;
      // buf_nxt already carries the final sample taken in this cycle
      if (done) begin
        if (!frame_valid || ack) begin
          frame       <= buf_nxt;
          frame_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (ack && frame_valid) begin
        frame_valid <= 1'b0;
      end
      if (state == ST_IDLE && start) overrun <= 1'b0;
    end
  end

  assign mux_e = (state == ST_IDLE);
  assign busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_mux151_scan_ctrl.sv
// Scoreboard bench for mux151_scan_ctrl with a behavioural 74HC151 on din.
module tb_mux151_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, cont, ack;
  logic       mux_y, mux_e, frame_valid, busy, overrun;
  logic [2:0] mux_sel;
  logic [7:0] frame;
  logic [7:0] din;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_cyc = 0;
  int t1 = 0;
  logic [7:0] exp_q[$];
  logic fv_prev = 1'b0;
  logic ack_q   = 1'b0;

  mux151_scan_ctrl #(.DATA_IN(8), .SEL_W(3), .SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .ack(ack),
    .mux_y(mux_y), .mux_e(mux_e), .mux_sel(mux_sel), .frame(frame),
    .frame_valid(frame_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  assign mux_y = mux_e ? 1'b0 : din[mux_sel];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    ack_q <= ack;
  end

  // A frame is delivered when valid rises, or stays high across an accepted handover
  always @(negedge clk) begin
    if (frame_valid && (!fv_prev || ack_q)) begin
      last_cyc = cyc;
      if (exp_q.size() == 0) chk("sb_empty", 1, 0);
      else chk("frame", frame, exp_q.pop_front());
    end
    fv_prev = frame_valid;
  end

  task automatic run_scan(input logic [7:0] d, input int glitch);
    logic fv0;
    din = d;
    exp_q.push_back(d);
    @(negedge clk);
    fv0 = frame_valid;
    start = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      start = (k == glitch);
      if (k <= 24) begin
        chk("mux_e_scan", mux_e, 0);
        chk("sel_step", mux_sel, (k - 1) / 3);
        chk("busy_scan", busy, 1);
        if (k == 24 && !fv0) chk("fv_early", frame_valid, 0);
      end else begin
        chk("fv_done", frame_valid, 1);
        chk("busy_done", busy, 0);
        chk("mux_e_done", mux_e, 1);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; cont = 1'b0; ack = 1'b0; din = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_mux_e", mux_e, 1);
    chk("rst_sel", mux_sel, 0);
    chk("rst_frame", frame, 0);
    chk("rst_fv", frame_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single shot, then hold without ack
    run_scan(8'hA5, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_frame", frame, 8'hA5);
      chk("hold_fv", frame_valid, 1);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
    chk("ack_fv", frame_valid, 0);

    // start while busy must not restart the scan
    run_scan(8'h5A, 7);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;

    // continuous, acked in the completion cycle, cont dropped in frame 2
    din = 8'h3C;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    cont = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 25) begin
        din = 8'hC3;
        chk("cont_busy", busy, 1);
        chk("cont_mux_e", mux_e, 0);
        chk("cont_sel0", mux_sel, 0);
      end
      if (k == 30) begin
        t1 = last_cyc;
        cont = 1'b0;
      end
      if (k == 48) begin
        chk("handover_fv_pre", frame_valid, 1);
        ack = 1'b1;
      end
      if (k == 49) begin
        ack = 1'b0;
        chk("handover_fv", frame_valid, 1);
        chk("handover_ovr", overrun, 0);
        chk("cont_stop_busy", busy, 0);
      end
      if (k == 50) chk("frame_gap", last_cyc - t1, 24);
      if (k > 50) begin
        chk("idle_sel", mux_sel, 0);
        chk("idle_mux_e", mux_e, 1);
      end
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
    chk("ack2_fv", frame_valid, 0);

    // continuous, no ack: second frame dropped
    din = 8'h0F;
    exp_q.push_back(8'h0F);
    cont = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 49; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 25) din = 8'hF0;
      if (k == 30) cont = 1'b0;
      if (k == 48) chk("ovr_pre", overrun, 0);
      if (k == 49) begin
        chk("ovr_set", overrun, 1);
        chk("ovr_fv", frame_valid, 1);
        chk("ovr_frame", frame, 8'h0F);
        chk("ovr_busy", busy, 0);
      end
    end

    // start in IDLE clears overrun
    din = 8'h99;
    exp_q.push_back(8'h99);
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      start = 1'b0;
      ack = (k == 1);
      if (k == 1) chk("ovr_clr", overrun, 0);
      if (k == 25) chk("fv_after_clr", frame_valid, 1);
    end

    // reset in the middle of a scan
    din = 8'h77;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 10) rst_n = 1'b0;
    end
    chk("mrst_mux_e", mux_e, 1);
    chk("mrst_sel", mux_sel, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_fv", frame_valid, 0);
    chk("mrst_frame", frame, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_scan(8'h6B, 0);

    repeat (5) @(negedge clk);
    chk("sb_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
